iwrr_weight_tracker: RTL and testbench

Sequential companion to the IWRR priority granter. It consumes the granter's accepted grants and counts them per requester against programmable weights. It drives the `request_weight_completed` vector back into the granter and closes each round once the weight budget is spent. Granter plus tracker together form the complete interleaved weighted round-robin arbiter.

---
 rtl/iwrr_weight_tracker.sv | 60 ++++++
 tb/tb_iwrr_weight_tracker.sv | 139 +++++++++++++
 2 files changed

// File: rtl/iwrr_weight_tracker.sv
// iwrr_weight_tracker: per-requester grant counting against weights, closing IWRR rounds
module iwrr_weight_tracker #(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_WEIGHT_W = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [P_REQUESTER_NUM-1:0]            request,
  input  logic [P_REQUESTER_NUM-1:0]            grant,
  input  logic                                  grant_accept,
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight_cfg,
  output logic [P_REQUESTER_NUM-1:0]            request_weight_completed,
  output logic                                  tracker_ready,
  output logic                                  round_done,
  output logic                                  grant_err
);
  typedef enum logic {S_LOAD, S_RUN} state_t;
  localparam logic [P_WEIGHT_W-1:0] ONE = P_WEIGHT_W'(1);
  state_t state, state_nxt;
  logic [P_REQUESTER_NUM-1:0][P_WEIGHT_W-1:0] cnt, weight_q;
  logic [P_REQUESTER_NUM-1:0] done_q;
  logic one_hot, round_end;
  assign one_hot = (grant != '0) && ((grant & (grant - P_REQUESTER_NUM'(1))) == '0);
  assign round_end = (&done_q) || ((request != '0) && ((request & ~done_q) == '0));
  assign request_weight_completed = (state == S_LOAD) ? '1 : done_q;
  assign tracker_ready = (state == S_RUN);
  always_comb begin
    state_nxt = S_RUN;
    state_nxt = (state == S_RUN && round_end) ? S_LOAD : S_RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
      cnt <= '0;
      weight_q <= '0;
      done_q <= '0;
      round_done <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      state <= state_nxt;
      round_done <= (state == S_RUN) && round_end;
      if (state == S_LOAD) begin
        weight_q <= weight_cfg;
        cnt <= '0;
        for (int i = 0; i < P_REQUESTER_NUM; i++)
          done_q[i] <= (weight_cfg[i*P_WEIGHT_W +: P_WEIGHT_W] == '0);
      end else if (grant_accept) begin
        if (one_hot) begin
          for (int i = 0; i < P_REQUESTER_NUM; i++)
            if (grant[i] && !done_q[i]) begin
              cnt[i] <= cnt[i] + ONE;
              if (cnt[i] + ONE == weight_q[i]) done_q[i] <= 1'b1;
            end
        end else if (grant != '0) begin
          grant_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_iwrr_weight_tracker.sv
// tb_iwrr_weight_tracker: scoreboard bench checking the tracker against a count-based model
module tb_iwrr_weight_tracker;
  localparam int N = 3;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] request, grant;
  logic grant_accept;
  logic [N*W-1:0] weight_cfg;
  logic [N-1:0] completed;
  logic tracker_ready, round_done, grant_err;
  iwrr_weight_tracker #(.P_REQUESTER_NUM(N), .P_WEIGHT_W(W)) dut (
    .clk(clk), .rst(rst), .request(request), .grant(grant), .grant_accept(grant_accept),
    .weight_cfg(weight_cfg), .request_weight_completed(completed), .tracker_ready(tracker_ready),
    .round_done(round_done), .grant_err(grant_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [N-1:0] comp;
    logic rdy;
    logic rd;
    logic err;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;
  int passes = 0;
  int checks = 0;
  bit m_load, m_rd, m_err;
  int m_cnt[N];
  int m_w[N];
  logic [N*W-1:0] wc;
  localparam logic [N*W-1:0] W_A = {4'd3, 4'd1, 4'd2};
  localparam logic [N*W-1:0] W_Z = {4'd3, 4'd0, 4'd2};
  localparam logic [N*W-1:0] W_1 = {4'd1, 4'd1, 4'd1};
  function automatic logic [N-1:0] m_comp();
    logic [N-1:0] c;
    for (int i = 0; i < N; i++) c[i] = (m_cnt[i] >= m_w[i]);
    return c;
  endfunction
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] g, input logic a, input logic [N*W-1:0] w);
    logic [N-1:0] c;
    bit fin;
    if (r) begin
      m_load = 1; m_rd = 0; m_err = 0;
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_w[i] = 0; end
    end else if (m_load) begin
      m_load = 0; m_rd = 0;
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_w[i] = int'(w[i*W +: W]); end
    end else begin
      c = m_comp();
      fin = (c == '1) || (rq != '0 && (rq & ~c) == '0);
      if (a && $countones(g) == 1) begin
        for (int i = 0; i < N; i++) if (g[i] && !c[i]) m_cnt[i]++;
      end else if (a && $countones(g) > 1) begin
        m_err = 1;
      end
      m_load = fin;
      m_rd = fin;
    end
  endtask
  task automatic cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] g, input logic a);
    @(posedge clk);
    #1;
    q.push_back('{comp: m_load ? '1 : m_comp(), rdy: !m_load, rd: m_rd, err: m_err});
    rst = r; request = rq; grant = g; grant_accept = a; weight_cfg = wc;
    step(r, rq, g, a, wc);
  endtask
  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%b required=%b at %0t", name, act, req, $time);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("completed", completed, mon_e.comp);
      chk("tracker_ready", N'(tracker_ready), N'(mon_e.rdy));
      chk("round_done", N'(round_done), N'(mon_e.rd));
      chk("grant_err", N'(grant_err), N'(mon_e.err));
    end
  end
  initial begin
    logic [N-1:0] g;
    wc = W_A;
    rst = 1; request = '0; grant = '0; grant_accept = 0; weight_cfg = wc;
    step(1, '0, '0, 0, wc);
    cycle(1, '0, '0, 0);
    cycle(0, 3'b111, '0, 0);
    repeat (2) cycle(0, 3'b111, 3'b001, 1);
    cycle(0, 3'b111, 3'b010, 1);
    repeat (3) cycle(0, 3'b111, 3'b100, 1);
    repeat (3) cycle(0, 3'b111, '0, 0);
    repeat (3) cycle(0, 3'b001, 3'b001, 1);
    repeat (3) cycle(0, 3'b001, '0, 0);
    wc = W_Z;
    cycle(1, '0, '0, 0);
    cycle(0, 3'b111, '0, 0);
    repeat (3) cycle(0, 3'b111, 3'b010, 1);
    cycle(0, 3'b111, 3'b001, 1);
    cycle(0, 3'b111, 3'b011, 1);
    cycle(0, 3'b111, 3'b000, 1);
    repeat (2) cycle(0, 3'b111, 3'b100, 1);
    repeat (2) cycle(0, 3'b111, '0, 0);
    wc = W_A;
    cycle(1, '0, '0, 0);
    cycle(0, 3'b111, 3'b000, 1);
    cycle(0, 3'b111, 3'b000, 1);
    repeat (2) cycle(0, 3'b111, 3'b001, 1);
    cycle(0, 3'b111, 3'b100, 1);
    repeat (2) cycle(1, 3'b111, 3'b100, 1);
    repeat (3) cycle(0, 3'b111, '0, 0);
    cycle(0, 3'b111, 3'b001, 1);
    wc = W_1;
    cycle(0, 3'b111, 3'b001, 1);
    cycle(0, 3'b111, 3'b010, 1);
    repeat (3) cycle(0, 3'b111, 3'b100, 1);
    repeat (2) cycle(0, 3'b111, '0, 0);
    cycle(0, 3'b111, 3'b001, 1);
    cycle(0, 3'b111, 3'b010, 1);
    cycle(0, 3'b111, 3'b100, 1);
    repeat (2) cycle(0, 3'b111, '0, 0);
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 49) == 0) wc = (N*W)'($urandom);
      case ($urandom_range(0, 9))
        7: g = '0;
        8, 9: g = N'($urandom);
        default: g = N'(1 << $urandom_range(0, N-1));
      endcase
      cycle($urandom_range(0, 199) == 0, N'($urandom), g, $urandom_range(0, 3) != 0);
    end
    cycle(0, '0, '0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
